// File: rtl/smul_sequencer_pkg.sv
// Shared definitions for the SMUL multiply controller: FSM state encodings
// and the opcode value the decoder matches to raise the start request.
package smul_sequencer_pkg;

    typedef enum logic [1:0] {
        SMUL_IDLE = 2'd0,
        SMUL_RUN  = 2'd1,
        SMUL_DONE = 2'd2
    } smul_state_e;

    localparam logic [5:0] SMUL_OPCODE = 6'h1C;

endpackage

// File: rtl/smul_sequencer_if.sv
// Decode-stage <-> multiply-controller bundle: request, operands, stall and
// the register-file write-back of the product.
interface smul_sequencer_if #(
    parameter int WIDTH  = 16,
    parameter int DEST_W = 8
);
    logic                 iStart;
    logic [WIDTH-1:0]     iA;
    logic [WIDTH-1:0]     iB;
    logic [DEST_W-1:0]    iDest;
    logic                 oBusy;
    logic                 oDone;
    logic                 oWriteEnable;
    logic [DEST_W-1:0]    oDest;
    logic [2*WIDTH-1:0]   oResult;

    modport master (
        output iStart, iA, iB, iDest,
        input  oBusy, oDone, oWriteEnable, oDest, oResult
    );

    modport slave (
        input  iStart, iA, iB, iDest,
        output oBusy, oDone, oWriteEnable, oDest, oResult
    );
endinterface

// File: rtl/smul_sequencer_booth_step.sv
// One radix-2 Booth iteration on the packed {acc, Q, q(-1)} register:
// conditional add/subtract of the multiplicand, then arithmetic shift right.
module smul_sequencer_booth_step #(
    parameter int WIDTH = 16
) (
    input  logic [2*WIDTH+1:0] cur_i,
    input  logic [WIDTH-1:0]   mcand_i,
    output logic [2*WIDTH+1:0] next_o
);
    logic [WIDTH:0] acc;
    logic [WIDTH:0] aExt;
    logic [WIDTH:0] sum;

    assign acc  = cur_i[2*WIDTH+1 -: WIDTH+1];
    assign aExt = {mcand_i[WIDTH-1], mcand_i};

    always_comb begin
        sum = acc;
        case (cur_i[1:0])
            2'b01:   sum = acc + aExt;
            2'b10:   sum = acc - aExt;
            default: sum = acc;
        endcase
    end

    // The shift drops the old q(-1); the old Q bit 0 becomes the new q(-1).
    assign next_o = {sum[WIDTH], sum, cur_i[WIDTH:1]};

endmodule

// File: rtl/smul_sequencer.sv
// Multi-cycle signed multiply controller: latches operands, runs WIDTH Booth
// steps, stalls the pipeline while busy and issues one write-back strobe.
module smul_sequencer
    import smul_sequencer_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int DEST_W = 8
) (
    input  logic              Clock,
    input  logic              Reset_n,
    smul_sequencer_if.slave   bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    smul_state_e          state_q, state_d;
    logic                 accept;
    logic [CNT_W-1:0]     count_q;
    logic [WIDTH-1:0]     mcand_q;
    logic [2*WIDTH+1:0]   booth_q;
    logic [2*WIDTH+1:0]   stepNext;
    logic [DEST_W-1:0]    latchDest_q;
    logic [DEST_W-1:0]    resultDest_q;
    logic [2*WIDTH-1:0]   result_q;

    smul_sequencer_booth_step #(.WIDTH(WIDTH)) uStep (
        .cur_i   (booth_q),
        .mcand_i (mcand_q),
        .next_o  (stepNext)
    );

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) state_q <= SMUL_IDLE;
        else          state_q <= state_d;
    end

    // A start in DONE is taken immediately so back-to-back SMULs lose no cycle.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            SMUL_IDLE: begin
                accept = bus.iStart;
                if (bus.iStart) state_d = SMUL_RUN;
            end
            SMUL_RUN: begin
                if (count_q == CNT_LAST) state_d = SMUL_DONE;
            end
            SMUL_DONE: begin
                accept  = bus.iStart;
                state_d = bus.iStart ? SMUL_RUN : SMUL_IDLE;
            end
            default: state_d = SMUL_IDLE;
        endcase
    end

    always_comb begin
        bus.oBusy        = (state_q != SMUL_IDLE);
        bus.oDone        = (state_q == SMUL_DONE);
        bus.oWriteEnable = (state_q == SMUL_DONE);
    end

    assign bus.oResult = result_q;
    assign bus.oDest   = resultDest_q;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            count_q      <= '0;
            mcand_q      <= '0;
            booth_q      <= '0;
            latchDest_q  <= '0;
            resultDest_q <= '0;
            result_q     <= '0;
        end else if (accept) begin
            count_q      <= '0;
            mcand_q      <= bus.iA;
            booth_q      <= {{(WIDTH+1){1'b0}}, bus.iB, 1'b0};
            latchDest_q  <= bus.iDest;
        end else if (state_q == SMUL_RUN) begin
            booth_q <= stepNext;
            count_q <= count_q + CNT_ONE;
            // Product is the low 2*WIDTH bits of {acc, Q}; the acc guard bit is dropped.
            if (count_q == CNT_LAST) begin
                result_q     <= stepNext[2*WIDTH:1];
                resultDest_q <= latchDest_q;
            end
        end
    end

endmodule

// File: tb/tb_smul_sequencer.sv
// Directed bench for the SMUL controller: products, latency, back-to-back
// issue, ignored mid-run starts and asynchronous abort.
module tb_smul_sequencer;

    logic Clock;
    logic Reset_n;
    int   testsRun;
    int   failCount;

    smul_sequencer_if #(.WIDTH(16), .DEST_W(8)) bus ();

    smul_sequencer #(.WIDTH(16), .DEST_W(8)) dut (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        testsRun++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic start, input logic [15:0] a,
                                 input logic [15:0] b, input logic [7:0] d);
        bus.iStart = start;
        bus.iA     = a;
        bus.iB     = b;
        bus.iDest  = d;
    endtask

    task automatic stepCycle();
        @(posedge Clock);
        @(negedge Clock);
    endtask

    // Called at the negedge right after the accepting edge.
    task automatic waitDone(output int cycles, output int busyCycles);
        cycles     = 0;
        busyCycles = 0;
        while (bus.oDone !== 1'b1 && cycles < 40) begin
            if (bus.oBusy === 1'b1) busyCycles++;
            stepCycle();
            cycles++;
        end
        if (bus.oBusy === 1'b1) busyCycles++;
    endtask

    task automatic doMul(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [7:0] d, input logic [31:0] expected);
        int lat;
        int busy;
        @(negedge Clock);
        applyStimulus(1'b1, a, b, d);
        stepCycle();
        applyStimulus(1'b0, 16'h0, 16'h0, 8'h0);
        waitDone(lat, busy);
        checkOutput({tag, "_latency"}, 64'(lat), 64'd16);
        checkOutput({tag, "_busyCycles"}, 64'(busy), 64'd17);
        checkOutput({tag, "_result"}, 64'(bus.oResult), 64'(expected));
        checkOutput({tag, "_dest"}, 64'(bus.oDest), 64'(d));
        checkOutput({tag, "_we"}, 64'(bus.oWriteEnable), 64'd1);
        stepCycle();
        checkOutput({tag, "_doneAfter"}, 64'(bus.oDone), 64'd0);
        checkOutput({tag, "_busyAfter"}, 64'(bus.oBusy), 64'd0);
    endtask

    logic [15:0] heldA [3] = '{16'd3, 16'hFFFE, 16'd100};
    logic [15:0] heldB [3] = '{16'd4, 16'd9, 16'hFF9C};
    logic [31:0] heldP [3] = '{32'd12, 32'hFFFFFFEE, 32'hFFFFD8F0};

    initial begin
        int lat;
        int busy;
        int k;
        int doneSeen;
        testsRun  = 0;
        failCount = 0;
        Reset_n   = 1'b1;
        applyStimulus(1'b0, 16'h0, 16'h0, 8'h0);
        #1 Reset_n = 1'b0;
        stepCycle();
        stepCycle();
        checkOutput("rst_busy", 64'(bus.oBusy), 64'd0);
        checkOutput("rst_done", 64'(bus.oDone), 64'd0);
        checkOutput("rst_result", 64'(bus.oResult), 64'd0);
        checkOutput("rst_dest", 64'(bus.oDest), 64'd0);
        Reset_n = 1'b1;
        stepCycle();
        checkOutput("rst_idle", 64'(bus.oBusy), 64'd0);

        doMul("m7x5", 16'hFFF9, 16'd5, 8'd3, 32'hFFFFFFDD);
        doMul("minxmin", 16'h8000, 16'h8000, 8'd10, 32'h40000000);
        doMul("minxmax", 16'h8000, 16'h7FFF, 8'd11, 32'hC0008000);
        doMul("zeroxm1", 16'h0000, 16'hFFFF, 8'd12, 32'h00000000);
        doMul("m1xm1", 16'hFFFF, 16'hFFFF, 8'd13, 32'h00000001);
        doMul("maxxmax", 16'h7FFF, 16'h7FFF, 8'd14, 32'h3FFF0001);

        // iStart held high: each DONE cycle presents the next operand pair.
        @(negedge Clock);
        applyStimulus(1'b1, heldA[0], heldB[0], 8'd1);
        stepCycle();
        for (int i = 0; i < 3; i++) begin
            waitDone(lat, busy);
            checkOutput($sformatf("held%0d_latency", i), 64'(lat), 64'd16);
            checkOutput($sformatf("held%0d_busy", i), 64'(busy), 64'd17);
            checkOutput($sformatf("held%0d_result", i), 64'(bus.oResult), 64'(heldP[i]));
            checkOutput($sformatf("held%0d_dest", i), 64'(bus.oDest), 64'(i + 1));
            if (i < 2) applyStimulus(1'b1, heldA[i+1], heldB[i+1], 8'(i + 2));
            else       applyStimulus(1'b0, 16'h0, 16'h0, 8'h0);
            stepCycle();
        end
        checkOutput("held_doneAfter", 64'(bus.oDone), 64'd0);
        checkOutput("held_busyAfter", 64'(bus.oBusy), 64'd0);

        // Start pulse in the middle of RUN must be dropped.
        @(negedge Clock);
        applyStimulus(1'b1, 16'd6, 16'd7, 8'd5);
        stepCycle();
        applyStimulus(1'b0, 16'h0, 16'h0, 8'h0);
        k = 0;
        while (bus.oDone !== 1'b1 && k < 40) begin
            if (k == 5) applyStimulus(1'b1, 16'd1234, 16'd5, 8'd9);
            else        applyStimulus(1'b0, 16'h0, 16'h0, 8'h0);
            stepCycle();
            k++;
        end
        applyStimulus(1'b0, 16'h0, 16'h0, 8'h0);
        checkOutput("ign_latency", 64'(k), 64'd16);
        checkOutput("ign_result", 64'(bus.oResult), 64'd42);
        checkOutput("ign_dest", 64'(bus.oDest), 64'd5);
        stepCycle();
        checkOutput("ign_busyAfter", 64'(bus.oBusy), 64'd0);

        // Asynchronous abort partway through RUN.
        @(negedge Clock);
        applyStimulus(1'b1, 16'd11, 16'd11, 8'd4);
        stepCycle();
        applyStimulus(1'b0, 16'h0, 16'h0, 8'h0);
        for (int i = 0; i < 8; i++) stepCycle();
        checkOutput("abort_busyBefore", 64'(bus.oBusy), 64'd1);
        #2 Reset_n = 1'b0;
        #1;
        checkOutput("abort_busy", 64'(bus.oBusy), 64'd0);
        checkOutput("abort_done", 64'(bus.oDone), 64'd0);
        checkOutput("abort_we", 64'(bus.oWriteEnable), 64'd0);
        checkOutput("abort_result", 64'(bus.oResult), 64'd0);
        checkOutput("abort_dest", 64'(bus.oDest), 64'd0);
        stepCycle();
        Reset_n  = 1'b1;
        doneSeen = 0;
        for (int i = 0; i < 20; i++) begin
            stepCycle();
            if (bus.oDone !== 1'b0) doneSeen++;
        end
        checkOutput("abort_noWrite", 64'(doneSeen), 64'd0);
        doMul("postAbort", 16'hFFFD, 16'hFFFC, 8'd7, 32'd12);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
